// File: rtl/tt_count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM states, ui_in/uio_out bit
// positions and the default prescaler size.
package tt_count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int PRE_DIV_LOG2_DEF = 4;

  localparam int UI_START    = 0;
  localparam int UI_STOP     = 1;
  localparam int UI_CLEAR    = 2;
  localparam int UI_AUTO     = 3;
  localparam int UI_DIR      = 4;
  localparam int UI_LD_LO    = 5;
  localparam int UI_LD_HI    = 6;
  localparam int UI_PRESCALE = 7;

  localparam int UIO_BUSY   = 7;
  localparam int UIO_PAUSED = 6;
  localparam int UIO_DONE   = 5;
  localparam int UIO_WRAP   = 4;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;
  localparam logic [7:0] TC_RESET   = 8'hFF;

endpackage

// File: rtl/tt_um_count_sequencer_if.sv
// Pin bundle of the count sequencer; the master side drives ena/ui_in/uio_in
// and observes the count and status pins.
interface tt_um_count_sequencer_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_count_sequencer_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one command input.
// All flops reset high so a line held high across reset never fires.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic rise
);
  logic s1_q, s1_d, s2_q, s2_d, hist_q, hist_d;

  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    hist_d = hist_q;
    if (ena) begin
      s1_d   = d;
      s2_d   = s1_q;
      hist_d = s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign rise = s2_q & ~hist_q;
endmodule

// File: rtl/tt_um_count_sequencer.sv
// Programmable up/down count sequencer: start/stop/clear commands, optional
// prescaled tick, terminal count with auto-reload or one-shot DONE.
module tt_um_count_sequencer
  import tt_count_seq_pkg::*;
#(
  parameter int PRE_DIV_LOG2 = PRE_DIV_LOG2_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [PRE_DIV_LOG2-1:0] PRE_ONE = PRE_DIV_LOG2'(1);

  logic [7:0] rise;

  for (genvar g = 0; g < 8; g++) begin : g_cmd
    if (g == UI_START || g == UI_STOP || g == UI_CLEAR || g == UI_LD_LO || g == UI_LD_HI) begin : g_edge
      edge_sync u_sync (.clk(clk), .rst_n(rst_n), .ena(ena), .d(ui_in[g]), .rise(rise[g]));
    end else begin : g_level
      assign rise[g] = 1'b0;
    end
  end

  // Level inputs: [0] auto_reload, [1] dir, [2] prescale_en
  logic [2:0] lvl1_q, lvl1_d, lvl2_q, lvl2_d;
  logic       lvl_auto, lvl_dir, lvl_pre;
  assign lvl_auto = lvl2_q[0];
  assign lvl_dir  = lvl2_q[1];
  assign lvl_pre  = lvl2_q[2];

  state_e                  state_q, state_d;
  logic [7:0]              count_q, count_d, tc_q, tc_d;
  logic [PRE_DIV_LOG2-1:0] pre_q, pre_d;
  logic                    dir_q, dir_d, wrap_q, wrap_d;
  logic                    tick, terminal;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = tc_q;
    pre_d    = pre_q;
    dir_d    = dir_q;
    wrap_d   = wrap_q;
    lvl1_d   = lvl1_q;
    lvl2_d   = lvl2_q;
    tick     = 1'b0;
    terminal = 1'b0;
    if (ena) begin
      lvl1_d = {ui_in[UI_PRESCALE], ui_in[UI_DIR], ui_in[UI_AUTO]};
      lvl2_d = lvl1_q;
      wrap_d = 1'b0;
      if (rise[UI_LD_LO]) tc_d[3:0] = uio_in[3:0];
      if (rise[UI_LD_HI]) tc_d[7:4] = uio_in[3:0];
      if (rise[UI_CLEAR]) begin
        state_d = ST_IDLE;
        count_d = 8'h00;
        pre_d   = '0;
      end else if (rise[UI_STOP]) begin
        if (state_q == ST_RUN) state_d = ST_PAUSE;
      end else if (rise[UI_START] && state_q != ST_RUN) begin
        state_d = ST_RUN;
        if (state_q != ST_PAUSE) begin
          dir_d   = lvl_dir;
          count_d = lvl_dir ? tc_q : 8'h00;
          pre_d   = '0;
        end
      end else if (state_q == ST_RUN) begin
        if (lvl_pre) begin
          pre_d = pre_q + PRE_ONE;
          tick  = &pre_q;
        end else begin
          tick = 1'b1;
        end
        if (tick) begin
          // Up mode also stops at 8'hFF so a TC lowered below count never wraps
          terminal = dir_q ? (count_q == 8'h00) : (count_q == tc_q || count_q == 8'hFF);
          if (!terminal) begin
            count_d = dir_q ? count_q - 8'd1 : count_q + 8'd1;
          end else if (lvl_auto) begin
            count_d = dir_q ? tc_q : 8'h00;
            wrap_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= 8'h00;
      tc_q    <= TC_RESET;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      lvl1_q  <= 3'b000;
      lvl2_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      lvl1_q  <= lvl1_d;
      lvl2_q  <= lvl2_d;
    end
  end

  always_comb begin
    uio_out             = 8'h00;
    uio_out[UIO_BUSY]   = (state_q == ST_RUN);
    uio_out[UIO_PAUSED] = (state_q == ST_PAUSE);
    uio_out[UIO_DONE]   = (state_q == ST_DONE);
    uio_out[UIO_WRAP]   = wrap_q;
  end

  assign uo_out = count_q;
  assign uio_oe = UIO_OE_VAL;

  logic unused_bits;
  assign unused_bits = &{1'b0, uio_in[7:4], rise[UI_AUTO], rise[UI_DIR], rise[UI_PRESCALE]};
endmodule

// File: tb/tb_tt_um_count_sequencer.sv
// Bench for tt_um_count_sequencer: directed vector table, corner-case
// sequences and random stimulus scored against a behavioural model.
module tb_tt_um_count_sequencer;
  localparam int P      = 4;
  localparam int PERIOD = 1 << P;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   n_chk = 0;

  tt_um_count_sequencer_if bus ();

  tt_um_count_sequencer #(.PRE_DIV_LOG2(P)) dut (
    .clk(clk), .rst_n(rst_n), .ena(bus.ena), .ui_in(bus.ui_in), .uio_in(bus.uio_in),
    .uo_out(bus.uo_out), .uio_out(bus.uio_out), .uio_oe(bus.uio_oe)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Commands become visible two edges after they are applied; the model keeps
  // the delayed copies of ui_in and applies the sequencer rules with ints.
  logic [15:0] exp_q[$];
  int          m_st, m_cnt, m_tc, m_pre;
  bit          m_wrap, m_dir;
  logic [7:0]  m_s1, m_s2, m_h;

  always @(posedge clk) begin : ref_model
    logic [7:0] rise, lvl;
    int         tc_new, lim, nxt;
    bit         tk;
    if (!rst_n) begin
      m_s1 = 8'h67; m_s2 = 8'h67; m_h = 8'h67;
      m_st = M_IDLE; m_cnt = 0; m_tc = 255; m_pre = 0; m_wrap = 0; m_dir = 0;
    end else if (bus.ena) begin
      rise   = m_s2 & ~m_h;
      lvl    = m_s2;
      tc_new = m_tc;
      m_wrap = 0;
      if (rise[5]) tc_new = (tc_new & 'hF0) | int'(bus.uio_in[3:0]);
      if (rise[6]) tc_new = (tc_new & 'h0F) | (int'(bus.uio_in[3:0]) << 4);
      if (rise[2]) begin
        m_st = M_IDLE; m_cnt = 0; m_pre = 0;
      end else if (rise[1]) begin
        if (m_st == M_RUN) m_st = M_PAUSE;
      end else if (rise[0] && m_st != M_RUN) begin
        if (m_st != M_PAUSE) begin
          m_dir = lvl[4]; m_cnt = m_dir ? m_tc : 0; m_pre = 0;
        end
        m_st = M_RUN;
      end else if (m_st == M_RUN) begin
        tk = 1;
        if (lvl[7]) begin
          m_pre = (m_pre + 1) % PERIOD;
          tk    = (m_pre == 0);
        end
        if (tk) begin
          lim = m_dir ? 0 : m_tc;
          nxt = m_dir ? m_cnt - 1 : m_cnt + 1;
          if (m_cnt == lim || nxt > 255) begin
            if (lvl[3]) begin m_cnt = m_dir ? m_tc : 0; m_wrap = 1; end
            else m_st = M_DONE;
          end else begin
            m_cnt = nxt;
          end
        end
      end
      m_tc = tc_new;
      m_h  = m_s2; m_s2 = m_s1; m_s1 = bus.ui_in;
    end
    exp_q.push_back({8'(m_cnt), m_st == M_RUN, m_st == M_PAUSE, m_st == M_DONE, m_wrap, 4'h0});
  end

  always @(negedge clk) begin : scoreboard
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("model_uo", bus.uo_out, e[15:8]);
      chk("model_status", bus.uio_out, e[7:0]);
      chk("uio_oe", bus.uio_oe, 8'hF0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_tc(input logic [7:0] v);
    bus.ui_in = 8'h00; bus.uio_in = {4'h0, v[7:4]}; tick_n(2);
    bus.ui_in = 8'h40; tick_n(3);
    bus.ui_in = 8'h00; bus.uio_in = {4'h0, v[3:0]}; tick_n(2);
    bus.ui_in = 8'h20; tick_n(3);
    bus.ui_in = 8'h00; bus.uio_in = 8'h00; tick_n(2);
  endtask

  typedef struct {
    int         op;   // 0 = apply and check, 1 = load TC
    logic       ena;
    logic [7:0] ui;
    logic [7:0] d;
    int         n;
    logic [7:0] uo;
    logic [3:0] st;   // {busy, paused, done, wrap}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vv(input logic e, input logic [7:0] ui, input int n,
                              input logic [7:0] uo, input logic [3:0] st);
    vec_t r;
    r.op = 0; r.ena = e; r.ui = ui; r.d = 8'h00; r.n = n; r.uo = uo; r.st = st;
    return r;
  endfunction

  function automatic vec_t ld(input logic [7:0] v);
    vec_t r;
    r.op = 1; r.ena = 1'b1; r.ui = 8'h00; r.d = v; r.n = 0; r.uo = 8'h00; r.st = 4'h0;
    return r;
  endfunction

  logic [7:0] rnd_u;

  // ---------------- stimulus ----------------
  initial begin
    bus.ena = 1'b1; bus.ui_in = 8'h00; bus.uio_in = 8'h00; rst_n = 1'b0;

    // one-shot up to 5
    tbl.push_back(ld(8'h05));
    tbl.push_back(vv(1, 8'h01, 3, 8'd0, 4'h8));
    for (int i = 1; i <= 5; i++) tbl.push_back(vv(1, 8'h01, 1, 8'(i), 4'h8));
    tbl.push_back(vv(1, 8'h01, 1, 8'd5, 4'h2));
    tbl.push_back(vv(1, 8'h01, 4, 8'd5, 4'h2));
    // auto-reload with TC = 3, then clear
    tbl.push_back(ld(8'h03));
    tbl.push_back(vv(1, 8'h09, 3, 8'd0, 4'h8));
    for (int i = 1; i <= 8; i++) tbl.push_back(vv(1, 8'h09, 1, 8'(i % 4), (i % 4 == 0) ? 4'h9 : 4'h8));
    tbl.push_back(vv(1, 8'h04, 3, 8'd0, 4'h0));
    // pause at 7, resume with prescaler, then start+stop+clear together at 9
    tbl.push_back(ld(8'h20));
    tbl.push_back(vv(1, 8'h01, 3, 8'd0, 4'h8));
    tbl.push_back(vv(1, 8'h01, 5, 8'd5, 4'h8));
    tbl.push_back(vv(1, 8'h03, 3, 8'd7, 4'h4));
    tbl.push_back(vv(1, 8'h03, 20, 8'd7, 4'h4));
    tbl.push_back(vv(1, 8'h00, 3, 8'd7, 4'h4));
    tbl.push_back(vv(1, 8'h81, 3, 8'd7, 4'h8));
    tbl.push_back(vv(1, 8'h81, 15, 8'd7, 4'h8));
    tbl.push_back(vv(1, 8'h81, 1, 8'd8, 4'h8));
    tbl.push_back(vv(1, 8'h81, 16, 8'd9, 4'h8));
    tbl.push_back(vv(1, 8'h80, 2, 8'd9, 4'h8));
    tbl.push_back(vv(1, 8'h87, 3, 8'd0, 4'h0));
    // prescaled down from 4
    tbl.push_back(ld(8'h04));
    tbl.push_back(vv(1, 8'h91, 3, 8'd4, 4'h8));
    tbl.push_back(vv(1, 8'h91, 15, 8'd4, 4'h8));
    tbl.push_back(vv(1, 8'h91, 1, 8'd3, 4'h8));
    tbl.push_back(vv(1, 8'h91, 48, 8'd0, 4'h8));
    tbl.push_back(vv(1, 8'h91, 15, 8'd0, 4'h8));
    tbl.push_back(vv(1, 8'h91, 1, 8'd0, 4'h2));
    // TC = 0 up: first tick is terminal
    tbl.push_back(ld(8'h00));
    tbl.push_back(vv(1, 8'h01, 3, 8'd0, 4'h8));
    tbl.push_back(vv(1, 8'h01, 1, 8'd0, 4'h2));
    // ena low freezes everything
    tbl.push_back(ld(8'h10));
    tbl.push_back(vv(1, 8'h01, 3, 8'd0, 4'h8));
    tbl.push_back(vv(1, 8'h01, 2, 8'd2, 4'h8));
    tbl.push_back(vv(0, 8'h01, 5, 8'd2, 4'h8));
    tbl.push_back(vv(1, 8'h01, 1, 8'd3, 4'h8));

    tick_n(3);
    chk("reset_uo", bus.uo_out, 8'h00);
    chk("reset_status", bus.uio_out, 8'h00);
    chk("reset_oe", bus.uio_oe, 8'hF0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].op == 1) begin
        load_tc(tbl[i].d);
      end else begin
        bus.ena = tbl[i].ena; bus.ui_in = tbl[i].ui; bus.uio_in = tbl[i].d;
        tick_n(tbl[i].n);
        chk($sformatf("v%0d_uo", i), bus.uo_out, tbl[i].uo);
        chk($sformatf("v%0d_status", i), {4'h0, bus.uio_out[7:4]}, {4'h0, tbl[i].st});
      end
    end

    // reset for one cycle mid-run, start held high across release
    rst_n = 1'b0; tick_n(1);
    chk("midrst_uo", bus.uo_out, 8'h00);
    chk("midrst_status", bus.uio_out, 8'h00);
    rst_n = 1'b1; tick_n(10);
    chk("heldstart_uo", bus.uo_out, 8'h00);
    chk("heldstart_status", bus.uio_out, 8'h00);
    bus.ui_in = 8'h00; tick_n(2);
    bus.ui_in = 8'h01; tick_n(3);
    chk("restart_uo", bus.uo_out, 8'h00);
    chk("restart_status", {4'h0, bus.uio_out[7:4]}, 8'h08);

    // random phase, checked by the model only
    for (int c = 0; c < 3000; c++) begin
      rnd_u = bus.ui_in;
      for (int b = 0; b < 8; b++) begin
        int r;
        r = (b == 2) ? 60 : ((b == 3 || b == 4 || b == 7) ? 40 : 6);
        if ($urandom_range(r - 1) == 0) rnd_u[b] = ~rnd_u[b];
      end
      bus.ui_in  = rnd_u;
      bus.uio_in = 8'($urandom_range(255));
      bus.ena    = ($urandom_range(19) != 0);
      rst_n      = ($urandom_range(799) != 0);
      tick_n(1);
    end
    rst_n = 1'b1; bus.ena = 1'b1;
    tick_n(2);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
